cache_mem_arbiter: RTL and testbench

- Shares the single memory/L2 port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Arbitrates among the three requesters and latches the missing block address.
- Issues 8 pipelined word reads for a fill, counts the returned words and steers each one into the owning cache's data array.
- Asserts a per-cache fill-complete pulse on the last word, and produces the pipeline stall signals.

---
 rtl/cache_mem_arbiter_pkg.sv | 16 +
 rtl/cache_mem_arbiter_fill_word_counter.sv | 26 ++
 rtl/cache_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory port arbiter: FSM state encoding
// and block/word address field positions.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_FILL = 2'd1,
    I_FILL = 2'd2,
    STORE  = 2'd3
  } arb_state_e;

  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned OFFSET_LSB    = 1;
  localparam int unsigned BLK_LSB       = 4;

endpackage

// File: rtl/cache_mem_arbiter_fill_word_counter.sv
// Word counter for block fills: increment enable, synchronous clear and a
// terminal-count flag; saturates only by the caller gating inc at tc.
module fill_word_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == '1);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between D-cache fills, write-through
// stores and I-cache fills; issues pipelined block reads and steers returns.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned WORDS_PER_BLK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] imiss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dmiss_addr,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              icache_wr_en,
  output logic              dcache_wr_en,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              store_ack,
  output logic              icache_stall,
  output logic              dcache_stall
);

  import cache_mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = $clog2(WORDS_PER_BLK);
  localparam int unsigned BLK_W = ADDR_W - BLK_LSB;

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [BLK_W-1:0]  blk;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [CNT_W-1:0]  iss;
  logic [CNT_W-1:0]  rcv;
  logic              iss_tc;
  logic              rcv_tc;
  logic              iss_done;
  logic              filling;
  logic              issuing;
  logic              beat;
  logic              last_beat;
  logic              unused_offset_bits;

  assign filling   = (state == D_FILL) || (state == I_FILL);
  assign issuing   = filling && !iss_done;
  assign beat      = filling && mem_valid;
  assign last_beat = beat && rcv_tc;

  // Both counters hold at 7 rather than wrapping; only a completed fill clears them.
  fill_word_counter #(.W(CNT_W)) u_iss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (issuing && !iss_tc),
    .clr   (last_beat),
    .count (iss),
    .tc    (iss_tc)
  );

  fill_word_counter #(.W(CNT_W)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (beat && !rcv_tc),
    .clr   (last_beat),
    .count (rcv),
    .tc    (rcv_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_done <= 1'b0;
    end else if (last_beat) begin
      iss_done <= 1'b0;
    end else if (issuing && iss_tc) begin
      iss_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk     <= '0;
      st_addr <= '0;
      st_data <= '0;
    end else if (state == IDLE) begin
      if (dcache_miss) begin
        blk <= dmiss_addr[ADDR_W-1:BLK_LSB];
      end else if (store_req) begin
        st_addr <= store_addr;
        st_data <= store_data;
      end else if (icache_miss) begin
        blk <= imiss_addr[ADDR_W-1:BLK_LSB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dcache_miss) begin
          state_nxt = D_FILL;
        end else if (store_req) begin
          state_nxt = STORE;
        end else if (icache_miss) begin
          state_nxt = I_FILL;
        end
      end
      D_FILL, I_FILL: begin
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en           = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    fill_addr        = '0;
    icache_wr_en     = 1'b0;
    dcache_wr_en     = 1'b0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;
    store_ack        = 1'b0;
    case (state)
      STORE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = st_addr;
        mem_wdata = st_data;
        store_ack = 1'b1;
      end
      D_FILL, I_FILL: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = {blk, iss, {OFFSET_LSB{1'b0}}};
        end
        if (beat) begin
          fill_addr        = {blk, rcv, {OFFSET_LSB{1'b0}}};
          icache_wr_en     = (state == I_FILL);
          dcache_wr_en     = (state == D_FILL);
          icache_fill_done = (state == I_FILL) && rcv_tc;
          dcache_fill_done = (state == D_FILL) && rcv_tc;
        end
      end
      default: ;
    endcase
  end

  assign fill_data    = mem_rdata;
  assign icache_stall = icache_miss && !icache_fill_done;
  assign dcache_stall = (dcache_miss && !dcache_fill_done) || (store_req && !store_ack);

  assign unused_offset_bits = ^{imiss_addr[BLK_LSB-1:0], dmiss_addr[BLK_LSB-1:0]};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: a transaction-level model predicts
// every output each cycle; a latency-programmable memory answers the reads.
module tb_cache_mem_arbiter;

  localparam int JOB_NONE = 0;
  localparam int JOB_I    = 1;
  localparam int JOB_D    = 2;
  localparam int JOB_ST   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, store_req;
  logic [15:0] imiss_addr, dmiss_addr, store_addr, store_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] fill_addr, fill_data;
  logic        icache_wr_en, dcache_wr_en, icache_fill_done, dcache_fill_done;
  logic        store_ack, icache_stall, dcache_stall;

  int total = 0;
  int bad   = 0;

  // reference model: current job and its progress in words
  int          job, issued, returned, grant_cyc, cyc, lat;
  logic [15:0] base, st_a, st_d;
  bit          rand_mode, spur_req, d_dropped;
  logic [15:0] mq_addr[$];
  int          mq_due[$];

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .imiss_addr(imiss_addr),
    .dcache_miss(dcache_miss), .dmiss_addr(dmiss_addr),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .icache_wr_en(icache_wr_en), .dcache_wr_en(dcache_wr_en),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .store_ack(store_ack), .icache_stall(icache_stall), .dcache_stall(dcache_stall)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  task automatic cycle();
    logic        e_men, e_mwr, e_iwr, e_dwr, e_idone, e_ddone, e_ack, e_ist, e_dst;
    logic [15:0] e_maddr, e_wdata, e_faddr;
    bit          beat, drop_i, drop_d, drop_s;
    @(negedge clk);
    e_men = 0; e_mwr = 0; e_iwr = 0; e_dwr = 0; e_idone = 0; e_ddone = 0; e_ack = 0;
    e_maddr = '0; e_wdata = '0; e_faddr = '0;
    beat = mem_valid && (job == JOB_I || job == JOB_D);
    if (job == JOB_ST) begin
      e_men = 1; e_mwr = 1; e_maddr = st_a; e_wdata = st_d; e_ack = 1;
    end else if (job == JOB_I || job == JOB_D) begin
      if (issued < 8) begin
        e_men = 1; e_maddr = base + 16'(2 * issued);
      end
      if (beat) begin
        e_faddr = base + 16'(2 * returned);
        e_iwr = (job == JOB_I);
        e_dwr = (job == JOB_D);
        e_idone = (job == JOB_I) && (returned == 7);
        e_ddone = (job == JOB_D) && (returned == 7);
      end
    end
    e_ist = icache_miss && !e_idone;
    e_dst = (dcache_miss && !e_ddone) || (store_req && !e_ack);

    check_val("mem_en", mem_en, e_men);
    if (e_men) begin
      check_val("mem_wr", mem_wr, e_mwr);
      check_val("mem_addr", mem_addr, e_maddr);
    end
    check_val("mem_wdata", mem_wdata, e_wdata);
    check_val("icache_wr_en", icache_wr_en, e_iwr);
    check_val("dcache_wr_en", dcache_wr_en, e_dwr);
    check_val("icache_fill_done", icache_fill_done, e_idone);
    check_val("dcache_fill_done", dcache_fill_done, e_ddone);
    check_val("store_ack", store_ack, e_ack);
    check_val("icache_stall", icache_stall, e_ist);
    check_val("dcache_stall", dcache_stall, e_dst);
    if (beat) begin
      check_val("fill_addr", fill_addr, e_faddr);
      check_val("fill_data", fill_data, word_of(e_faddr));
    end
    if (e_idone || e_ddone) check_val("fill_latency", cyc - grant_cyc, 8 + lat);

    if (mem_en && !mem_wr) begin
      mq_addr.push_back(mem_addr);
      mq_due.push_back(cyc + lat);
    end

    // advance the model with the inputs the DUT sees at this edge
    if (job == JOB_NONE) begin
      grant_cyc = cyc;
      if (dcache_miss) begin
        job = JOB_D; base = dmiss_addr & 16'hFFF0;
      end else if (store_req) begin
        job = JOB_ST; st_a = store_addr; st_d = store_data;
      end else if (icache_miss) begin
        job = JOB_I; base = imiss_addr & 16'hFFF0;
      end
    end else if (job == JOB_ST) begin
      job = JOB_NONE;
    end else begin
      if (issued < 8) issued++;
      if (beat) returned++;
      if (returned == 8) begin
        job = JOB_NONE; issued = 0; returned = 0;
      end
    end
    drop_i = e_idone; drop_d = e_ddone; drop_s = e_ack;

    @(posedge clk);
    #1;
    cyc++;
    if (drop_i) icache_miss = 0;
    if (drop_d) begin dcache_miss = 0; d_dropped = 0; end
    if (drop_s) store_req = 0;

    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_valid = 1;
      mem_rdata = word_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else if ((spur_req || (rand_mode && $urandom_range(0, 15) == 0)) &&
                 (job == JOB_NONE || job == JOB_ST) && mq_addr.size() == 0) begin
      mem_valid = 1;
      mem_rdata = spur_req ? 16'hDEAD : 16'($urandom);
      spur_req = 0;
    end else begin
      mem_valid = 0;
      mem_rdata = 16'($urandom);
    end

    if (rand_mode) begin
      if (job == JOB_NONE && mq_addr.size() == 0 && $urandom_range(0, 7) == 0)
        lat = $urandom_range(1, 6);
      if (!icache_miss && !drop_i && $urandom_range(0, 9) == 0) begin
        icache_miss = 1; imiss_addr = 16'($urandom);
      end
      if (!dcache_miss && !drop_d && !d_dropped && $urandom_range(0, 9) == 0) begin
        dcache_miss = 1; dmiss_addr = 16'($urandom);
      end
      if (!store_req && !drop_s && $urandom_range(0, 11) == 0) begin
        store_req = 1; store_addr = 16'($urandom); store_data = 16'($urandom);
      end
      if (job == JOB_D && dcache_miss && returned >= 1 && $urandom_range(0, 19) == 0) begin
        dcache_miss = 0; d_dropped = 1;
      end
    end
  endtask

  task automatic run_idle();
    int k;
    k = 0;
    while (!(job == JOB_NONE && !icache_miss && !dcache_miss && !store_req && mq_addr.size() == 0)) begin
      if (k == 400) begin
        check_val("idle_timeout", 1, 0);
        return;
      end
      cycle();
      k++;
    end
  endtask

  initial begin
    rst = 1;
    icache_miss = 0; dcache_miss = 0; store_req = 0;
    imiss_addr = '0; dmiss_addr = '0; store_addr = '0; store_data = '0;
    mem_valid = 0; mem_rdata = '0;
    job = JOB_NONE; issued = 0; returned = 0; grant_cyc = 0; cyc = 0; lat = 4;
    base = '0; st_a = '0; st_d = '0;
    rand_mode = 0; spur_req = 0; d_dropped = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mem_en", mem_en, 0);
    check_val("rst_mem_wr", mem_wr, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_fill_addr", fill_addr, 0);
    check_val("rst_icache_wr_en", icache_wr_en, 0);
    check_val("rst_dcache_wr_en", dcache_wr_en, 0);
    check_val("rst_icache_fill_done", icache_fill_done, 0);
    check_val("rst_dcache_fill_done", dcache_fill_done, 0);
    check_val("rst_store_ack", store_ack, 0);
    check_val("rst_icache_stall", icache_stall, 0);
    check_val("rst_dcache_stall", dcache_stall, 0);
    rst = 0;

    // I miss with 4-cycle memory
    imiss_addr = 16'h1234; icache_miss = 1;
    run_idle();

    // simultaneous I and D miss: D first
    lat = 3; imiss_addr = 16'h0040; dmiss_addr = 16'h8006;
    icache_miss = 1; dcache_miss = 1;
    run_idle();

    // store arriving mid I fill waits for the fill
    lat = 5; imiss_addr = 16'h0A10; icache_miss = 1;
    for (int k = 0; k < 50 && !(job == JOB_I && issued >= 3); k++) cycle();
    store_addr = 16'h2002; store_data = 16'hBEEF; store_req = 1;
    run_idle();

    // spurious beat in idle, then a normal D fill
    spur_req = 1;
    cycle();
    cycle();
    dmiss_addr = 16'h3338; dcache_miss = 1;
    run_idle();

    // reset after three words of a D fill
    lat = 2; dmiss_addr = 16'h4560; dcache_miss = 1;
    for (int k = 0; k < 50 && !(job == JOB_D && returned >= 3); k++) cycle();
    rst = 1; dcache_miss = 0;
    #1;
    check_val("midrst_mem_en", mem_en, 0);
    check_val("midrst_mem_addr", mem_addr, 0);
    check_val("midrst_dcache_wr_en", dcache_wr_en, 0);
    check_val("midrst_dcache_fill_done", dcache_fill_done, 0);
    job = JOB_NONE; issued = 0; returned = 0;
    #1;
    rst = 0;
    for (int k = 0; k < 20 && mq_addr.size() > 0; k++) cycle();
    dmiss_addr = 16'h4570; dcache_miss = 1;
    run_idle();

    // D miss dropped after two words still completes
    lat = 1; dmiss_addr = 16'h9AB0; dcache_miss = 1;
    for (int k = 0; k < 50 && !(job == JOB_D && returned >= 2); k++) cycle();
    dcache_miss = 0; d_dropped = 1;
    run_idle();

    rand_mode = 1;
    repeat (3000) cycle();
    rand_mode = 0;
    run_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
